// File: rtl/ysyx_trap_pkg.sv
// Shared types and constants for the EXU trap controller.
// YSYX_XLEN sets the datapath width and defaults to 32 when the build does not provide it.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

package ysyx_trap_pkg;

    localparam int TRAP_XLEN = `YSYX_XLEN;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_COMMIT,
        ST_REDIRECT
    } trap_state_e;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_IRQ,
        EV_EXC,
        EV_ECALL,
        EV_EBREAK,
        EV_MRET
    } trap_event_e;

    localparam int IRQ_MEI = 11;
    localparam int IRQ_MSI = 3;
    localparam int IRQ_MTI = 7;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    // Interrupts and synchronous exceptions share the csr_trap path.
    function automatic logic event_is_trap(input trap_event_e kind);
        return (kind == EV_IRQ) || (kind == EV_EXC);
    endfunction

endpackage

// File: rtl/ysyx_irq_prio.sv
// Fixed-priority machine interrupt select: MEI > MSI > MTI.
// Input is already masked by mie; output cause has the interrupt bit set.
module ysyx_irq_prio
    import ysyx_trap_pkg::*;
#(
    parameter int XLEN = TRAP_XLEN
) (
    input  logic [XLEN-1:0] pend_en,
    output logic            take,
    output logic [XLEN-1:0] cause
);

    logic unused_pend;

    assign unused_pend = ^pend_en;

    always_comb begin
        take  = 1'b0;
        cause = '0;
        if (pend_en[IRQ_MEI]) begin
            take  = 1'b1;
            cause = {1'b1, (XLEN-1)'(IRQ_MEI)};
        end else if (pend_en[IRQ_MSI]) begin
            take  = 1'b1;
            cause = {1'b1, (XLEN-1)'(IRQ_MSI)};
        end else if (pend_en[IRQ_MTI]) begin
            take  = 1'b1;
            cause = {1'b1, (XLEN-1)'(IRQ_MTI)};
        end
    end

endmodule

// File: rtl/ysyx_exu_trap_ctrl.sv
// Sequences interrupts, exceptions, ecall/ebreak/mret into one CSR update and one fetch redirect.
// Define YSYX_TRAP_VECTORED_EN to send interrupts to base + 4*cause when mtvec.MODE is vectored.
//
// state    | meaning
// IDLE     | watch the commit slot, pick at most one event
// DRAIN    | pipeline flushed, waiting on the store buffer (bounded by DRAIN_MAX)
// COMMIT   | one-cycle CSR update strobe
// REDIRECT | one-cycle fetch redirect, then back to IDLE
module ysyx_exu_trap_ctrl
    import ysyx_trap_pkg::*;
#(
    parameter int XLEN      = TRAP_XLEN,
    parameter int DRAIN_MAX = 255
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cmt_valid,
    input  logic [XLEN-1:0] cmt_pc,
    input  logic            cmt_ecall,
    input  logic            cmt_ebreak,
    input  logic            cmt_mret,
    input  logic            cmt_exc,
    input  logic [XLEN-1:0] cmt_cause,
    input  logic [XLEN-1:0] cmt_tval,
    output logic            cmt_ready,
    input  logic            irq_meip,
    input  logic            irq_msip,
    input  logic            irq_mtip,
    input  logic [XLEN-1:0] csr_mie,
    input  logic            csr_mstatus_mie,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    input  logic            sb_empty,
    output logic            csr_valid,
    output logic            csr_ecall,
    output logic            csr_ebreak,
    output logic            csr_mret,
    output logic            csr_trap,
    output logic [XLEN-1:0] csr_pc,
    output logic [XLEN-1:0] csr_cause,
    output logic [XLEN-1:0] csr_tval,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy,
    output logic            drain_timeout
);

    localparam int               CNT_W    = $clog2(DRAIN_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX);
    localparam logic [CNT_W-1:0] CNT_WARN = CNT_W'(DRAIN_MAX - 1);

    trap_state_e      state;
    trap_event_e      ev_kind;
    logic [XLEN-1:0]  ev_pc;
    logic [XLEN-1:0]  ev_cause;
    logic [XLEN-1:0]  ev_tval;
    logic [CNT_W-1:0] drain_cnt;

    logic [XLEN-1:0]  irq_pend;
    logic [XLEN-1:0]  irq_cause;
    logic             irq_hit;
    logic             irq_take;
    trap_event_e      nxt_kind;
    logic [XLEN-1:0]  nxt_cause;
    logic [XLEN-1:0]  nxt_tval;
    logic [XLEN-1:0]  trap_base;
    logic [XLEN-1:0]  target;
    logic             unused_mtvec_mode;

    always_comb begin
        irq_pend          = '0;
        irq_pend[IRQ_MEI] = irq_meip;
        irq_pend[IRQ_MSI] = irq_msip;
        irq_pend[IRQ_MTI] = irq_mtip;
    end

    ysyx_irq_prio #(
        .XLEN (XLEN)
    ) u_irq_prio (
        .pend_en (irq_pend & csr_mie),
        .take    (irq_hit),
        .cause   (irq_cause)
    );

    assign irq_take = csr_mstatus_mie & irq_hit;

    always_comb begin
        nxt_kind  = EV_NONE;
        nxt_cause = '0;
        nxt_tval  = '0;
        if (irq_take) begin
            nxt_kind  = EV_IRQ;
            nxt_cause = irq_cause;
        end else if (cmt_exc) begin
            nxt_kind  = EV_EXC;
            nxt_cause = cmt_cause;
            nxt_tval  = cmt_tval;
        end else if (cmt_ebreak) begin
            nxt_kind  = EV_EBREAK;
        end else if (cmt_ecall) begin
            nxt_kind  = EV_ECALL;
        end else if (cmt_mret) begin
            nxt_kind  = EV_MRET;
        end
    end

    // Consumption is decided in the same cycle the instruction sits in the slot; an interrupt leaves it unretired.
    assign cmt_ready = !reset && (state == ST_IDLE) && cmt_valid && !irq_take;
    assign busy      = (state != ST_IDLE);
    assign csr_pc    = ev_pc;
    assign csr_cause = ev_cause;
    assign csr_tval  = ev_tval;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            ev_kind        <= EV_NONE;
            ev_pc          <= '0;
            ev_cause       <= '0;
            ev_tval        <= '0;
            drain_cnt      <= '0;
            flush          <= 1'b0;
            csr_valid      <= 1'b0;
            csr_trap       <= 1'b0;
            csr_ecall      <= 1'b0;
            csr_ebreak     <= 1'b0;
            csr_mret       <= 1'b0;
            redirect_valid <= 1'b0;
            drain_timeout  <= 1'b0;
        end else begin
            flush          <= 1'b0;
            csr_valid      <= 1'b0;
            csr_trap       <= 1'b0;
            csr_ecall      <= 1'b0;
            csr_ebreak     <= 1'b0;
            csr_mret       <= 1'b0;
            redirect_valid <= 1'b0;
            drain_timeout  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cmt_valid && (nxt_kind != EV_NONE)) begin
                        ev_kind   <= nxt_kind;
                        ev_pc     <= cmt_pc;
                        ev_cause  <= nxt_cause;
                        ev_tval   <= nxt_tval;
                        drain_cnt <= '0;
                        flush     <= 1'b1;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (sb_empty || (drain_cnt == CNT_LAST)) begin
                        csr_valid  <= 1'b1;
                        csr_trap   <= event_is_trap(ev_kind);
                        csr_ecall  <= (ev_kind == EV_ECALL);
                        csr_ebreak <= (ev_kind == EV_EBREAK);
                        csr_mret   <= (ev_kind == EV_MRET);
                        state      <= ST_COMMIT;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                        // Raise the pulse so it lines up with the last DRAIN cycle, when the count hits its limit.
                        if (drain_cnt == CNT_WARN) begin
                            drain_timeout <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    redirect_valid <= 1'b1;
                    state          <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign unused_mtvec_mode = (csr_mtvec[1:0] == MTVEC_MODE_VECTORED);
    assign trap_base         = {csr_mtvec[XLEN-1:2], 2'b00};

    // Target reads the live CSRs in REDIRECT so the COMMIT-cycle write is already visible.
    always_comb begin
        target = trap_base;
        if (ev_kind == EV_MRET) begin
            target = csr_mepc;
`ifdef YSYX_TRAP_VECTORED_EN
        end else if ((ev_kind == EV_IRQ) && (csr_mtvec[1:0] == MTVEC_MODE_VECTORED)) begin
            target = trap_base + {ev_cause[XLEN-3:0], 2'b00};
`endif
        end
        redirect_pc = redirect_valid ? target : '0;
    end

endmodule

// File: tb/tb_ysyx_exu_trap_ctrl.sv
// Self-checking bench for ysyx_exu_trap_ctrl: directed cases plus randomized events against a transaction-level model.
module tb_ysyx_exu_trap_ctrl;

    localparam int XLEN = 32;
    localparam int DMAX = 255;

    localparam int K_NONE   = 0;
    localparam int K_IRQ    = 1;
    localparam int K_EXC    = 2;
    localparam int K_EBREAK = 3;
    localparam int K_ECALL  = 4;
    localparam int K_MRET   = 5;

    logic            clock;
    logic            reset;
    logic            cmt_valid;
    logic [XLEN-1:0] cmt_pc;
    logic            cmt_ecall;
    logic            cmt_ebreak;
    logic            cmt_mret;
    logic            cmt_exc;
    logic [XLEN-1:0] cmt_cause;
    logic [XLEN-1:0] cmt_tval;
    logic            cmt_ready;
    logic            irq_meip;
    logic            irq_msip;
    logic            irq_mtip;
    logic [XLEN-1:0] csr_mie;
    logic            csr_mstatus_mie;
    logic [XLEN-1:0] csr_mtvec;
    logic [XLEN-1:0] csr_mepc;
    logic            sb_empty;
    logic            csr_valid;
    logic            csr_ecall;
    logic            csr_ebreak;
    logic            csr_mret;
    logic            csr_trap;
    logic [XLEN-1:0] csr_pc;
    logic [XLEN-1:0] csr_cause;
    logic [XLEN-1:0] csr_tval;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            busy;
    logic            drain_timeout;

    int n_pass  = 0;
    int n_total = 0;

    ysyx_exu_trap_ctrl #(
        .XLEN      (XLEN),
        .DRAIN_MAX (DMAX)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .cmt_valid       (cmt_valid),
        .cmt_pc          (cmt_pc),
        .cmt_ecall       (cmt_ecall),
        .cmt_ebreak      (cmt_ebreak),
        .cmt_mret        (cmt_mret),
        .cmt_exc         (cmt_exc),
        .cmt_cause       (cmt_cause),
        .cmt_tval        (cmt_tval),
        .cmt_ready       (cmt_ready),
        .irq_meip        (irq_meip),
        .irq_msip        (irq_msip),
        .irq_mtip        (irq_mtip),
        .csr_mie         (csr_mie),
        .csr_mstatus_mie (csr_mstatus_mie),
        .csr_mtvec       (csr_mtvec),
        .csr_mepc        (csr_mepc),
        .sb_empty        (sb_empty),
        .csr_valid       (csr_valid),
        .csr_ecall       (csr_ecall),
        .csr_ebreak      (csr_ebreak),
        .csr_mret        (csr_mret),
        .csr_trap        (csr_trap),
        .csr_pc          (csr_pc),
        .csr_cause       (csr_cause),
        .csr_tval        (csr_tval),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .busy            (busy),
        .drain_timeout   (drain_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of run, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One commit-slot event from the IDLE cycle back to IDLE; expectations come from the event rules, not DUT state.
    task automatic run_txn(input logic ec, input logic eb, input logic mr, input logic ex,
                           input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval,
                           input logic [2:0] irq, input logic [31:0] mie, input logic mst,
                           input int sb_wait);
        logic [31:0] pend;
        logic [31:0] en;
        logic [31:0] e_cause;
        logic [31:0] e_tval;
        logic [31:0] e_tgt;
        logic [31:0] base;
        int          prio [3];
        int          kind;
        int          idx;
        int          d;
        bit          take;
        bit          tmo;

        prio     = '{11, 3, 7};
        pend     = '0;
        pend[11] = irq[2];
        pend[3]  = irq[1];
        pend[7]  = irq[0];
        en       = pend & mie;
        take     = mst && (en != 0);
        idx      = 0;
        for (int i = 0; i < 3; i++) begin
            if (idx == 0 && en[prio[i]]) idx = prio[i];
        end
        if (take)    kind = K_IRQ;
        else if (ex) kind = K_EXC;
        else if (eb) kind = K_EBREAK;
        else if (ec) kind = K_ECALL;
        else if (mr) kind = K_MRET;
        else         kind = K_NONE;
        e_cause = take ? (32'h8000_0000 | idx) : cause;
        e_tval  = take ? 32'h0 : tval;
        base    = csr_mtvec & ~32'h3;
        e_tgt   = (kind == K_MRET) ? csr_mepc : base;
`ifdef YSYX_TRAP_VECTORED_EN
        if (kind == K_IRQ && csr_mtvec[1:0] == 2'b01) e_tgt = base + 4 * idx;
`endif
        d   = ((sb_wait < DMAX) ? sb_wait : DMAX) + 1;
        tmo = (sb_wait >= DMAX);

        cmt_valid = 1'b1;
        cmt_ecall = ec;
        cmt_ebreak = eb;
        cmt_mret = mr;
        cmt_exc = ex;
        cmt_pc = pc;
        cmt_cause = cause;
        cmt_tval = tval;
        {irq_meip, irq_msip, irq_mtip} = irq;
        csr_mie = mie;
        csr_mstatus_mie = mst;
        sb_empty = (sb_wait == 0);
        @(negedge clock);
        chk("evt_ready", cmt_ready, !take);
        chk("evt_busy", busy, 0);

        if (kind == K_NONE) begin
            tick();
            cmt_valid = 1'b0;
            @(negedge clock);
            chk("none_busy", busy, 0);
            chk("none_flush", flush, 0);
            chk("none_csr_valid", csr_valid, 0);
            tick();
            return;
        end

        for (int k = 0; k < d; k++) begin
            tick();
            {irq_meip, irq_msip, irq_mtip} = 3'($urandom_range(0, 7));
            sb_empty = (k >= sb_wait);
            @(negedge clock);
            chk("drain_flush", flush, (k == 0));
            chk("drain_busy", busy, 1);
            chk("drain_ready", cmt_ready, 0);
            chk("drain_csr_valid", csr_valid, 0);
            chk("drain_timeout", drain_timeout, (tmo && k == d - 1));
        end

        tick();
        sb_empty = 1'($urandom_range(0, 1));
        @(negedge clock);
        chk("commit_valid", csr_valid, 1);
        chk("commit_trap", csr_trap, (kind == K_IRQ || kind == K_EXC));
        chk("commit_ecall", csr_ecall, (kind == K_ECALL));
        chk("commit_ebreak", csr_ebreak, (kind == K_EBREAK));
        chk("commit_mret", csr_mret, (kind == K_MRET));
        chk("commit_pc", csr_pc, pc);
        if (kind == K_IRQ || kind == K_EXC) begin
            chk("commit_cause", csr_cause, e_cause);
            chk("commit_tval", csr_tval, e_tval);
        end
        chk("commit_redirect", redirect_valid, 0);
        chk("commit_timeout", drain_timeout, 0);

        tick();
        cmt_ecall = 1'b0;
        cmt_ebreak = 1'b0;
        cmt_mret = 1'b0;
        cmt_exc = 1'b0;
        {irq_meip, irq_msip, irq_mtip} = 3'b000;
        @(negedge clock);
        chk("redir_valid", redirect_valid, 1);
        chk("redir_pc", redirect_pc, e_tgt);
        chk("redir_csr_valid", csr_valid, 0);
        chk("redir_ready", cmt_ready, 0);

        tick();
        @(negedge clock);
        chk("back_ready", cmt_ready, 1);
        chk("back_busy", busy, 0);
        chk("back_redirect", redirect_valid, 0);
        tick();
        cmt_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cmt_valid = 1'b1;
        cmt_pc = 32'h8000_0000;
        cmt_ecall = 1'b0;
        cmt_ebreak = 1'b0;
        cmt_mret = 1'b0;
        cmt_exc = 1'b0;
        cmt_cause = '0;
        cmt_tval = '0;
        irq_meip = 1'b0;
        irq_msip = 1'b0;
        irq_mtip = 1'b0;
        csr_mie = '0;
        csr_mstatus_mie = 1'b0;
        csr_mtvec = 32'h8000_0100;
        csr_mepc = '0;
        sb_empty = 1'b1;

        tick();
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmt_ready, 0);
        chk("rst_csr_valid", csr_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_redirect", redirect_valid, 0);
        chk("rst_timeout", drain_timeout, 0);
        chk("rst_csr_pc", csr_pc, 0);
        chk("rst_csr_cause", csr_cause, 0);

        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmt_pc = 32'h8000_0000 + 4 * i;
            @(negedge clock);
            chk("plain_ready", cmt_ready, 1);
            chk("plain_busy", busy, 0);
            chk("plain_flush", flush, 0);
            chk("plain_csr_valid", csr_valid, 0);
            tick();
        end

        csr_mtvec = 32'h8000_0100;
        run_txn(1, 0, 0, 0, 32'h8000_0010, 0, 0, 3'b000, 0, 0, 0);

        csr_mepc = 32'h8000_0044;
        run_txn(0, 0, 1, 0, 32'h8000_0020, 0, 0, 3'b000, 0, 0, 4);

        csr_mtvec = 32'h8000_0101;
        run_txn(1, 0, 0, 0, 32'h8000_0030, 0, 0, 3'b101, 32'h888, 1, 0);

        csr_mtvec = 32'h8000_0100;
        run_txn(0, 1, 0, 1, 32'h8000_0040, 32'd2, 32'hdead_beef, 3'b000, 0, 0, 1);
        run_txn(1, 1, 0, 0, 32'h8000_0050, 0, 0, 3'b000, 0, 0, 2);
        run_txn(1, 0, 0, 0, 32'h8000_0060, 0, 0, 3'b111, 32'h888, 0, 0);
        run_txn(0, 0, 0, 0, 32'h8000_0070, 0, 0, 3'b011, 32'h888, 1, 3);
        run_txn(0, 0, 0, 0, 32'h8000_0080, 0, 0, 3'b001, 32'h888, 1, 0);
        run_txn(0, 0, 0, 0, 32'h8000_0090, 0, 0, 3'b111, 32'h000, 1, 0);
        run_txn(1, 0, 0, 0, 32'h8000_00a0, 0, 0, 3'b000, 0, 0, 300);
        run_txn(0, 1, 0, 0, 32'h8000_00b0, 0, 0, 3'b000, 0, 0, DMAX - 1);

        cmt_valid = 1'b1;
        cmt_ecall = 1'b1;
        cmt_pc = 32'h8000_00c0;
        sb_empty = 1'b0;
        @(negedge clock);
        chk("rstseq_evt_ready", cmt_ready, 1);
        tick();
        cmt_valid = 1'b0;
        cmt_ecall = 1'b0;
        @(negedge clock);
        chk("rstseq_drain_busy", busy, 1);
        tick();
        reset = 1'b1;
        cmt_valid = 1'b1;
        tick();
        @(negedge clock);
        chk("rstseq_busy", busy, 0);
        chk("rstseq_csr_valid", csr_valid, 0);
        chk("rstseq_ready", cmt_ready, 0);
        tick();
        reset = 1'b0;
        cmt_valid = 1'b0;
        sb_empty = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("rstseq_after_valid", csr_valid, 0);
            chk("rstseq_after_busy", busy, 0);
            tick();
        end

        for (int t = 0; t < 40; t++) begin
            logic [3:0]  fl;
            logic [31:0] mie_r;
            fl = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) fl = 4'b0000;
            mie_r = ($urandom_range(0, 1) == 1) ? 32'h888 : $urandom;
            csr_mtvec = $urandom;
            csr_mepc = $urandom & ~32'h3;
            run_txn(fl[0], fl[1], fl[2], fl[3], $urandom & ~32'h3, $urandom_range(0, 15), $urandom,
                    3'($urandom_range(0, 7)), mie_r, 1'($urandom_range(0, 1)), $urandom_range(0, 6));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
